// File: rtl/fpadd_share_arbiter_if.sv
// fpadd_share_arbiter_if: bundles the requester, shared-adder and response signals of fpadd_share_arbiter.
// Ports: req_valid/req_ready/req_a/req_b carry operand pairs, with 32 bits per requester in req_a/req_b.
//        add_a/add_b/add_valid/add_res connect to the shared adder.
//        rsp_valid/rsp_data/rsp_ready return the held results.
//        busy reports that some requester is not idle.
// The slave modport is the arbiter's view. The master modport is the view of the requesters plus the adder.
interface fpadd_share_arbiter_if #(parameter int NREQ = 4);
  logic [NREQ-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*32-1:0] req_a, req_b, rsp_data;
  logic [31:0] add_a, add_b, add_res;
  logic add_valid, busy;
  modport master (
    output req_valid, req_a, req_b, rsp_ready, add_res,
    input req_ready, add_a, add_b, add_valid, rsp_valid, rsp_data, busy
  );
  modport slave (
    input req_valid, req_a, req_b, rsp_ready, add_res,
    output req_ready, add_a, add_b, add_valid, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/fpadd_share_arbiter.sv
// fpadd_share_arbiter: round-robin sharing of one fixed-latency FP adder among NREQ requesters.
// Ports: clk is the clock. rst is an asynchronous active-high reset. bus is the slave side of fpadd_share_arbiter_if.
//        Through bus the block grants one requester per cycle and drives the adder operands.
//        It tracks each in-flight sum by tag and holds every result until that requester accepts it.
module fpadd_share_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT = 2
) (
  input logic clk,
  input logic rst,
  fpadd_share_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, INFLIGHT, DONE} st_t;
  st_t state [NREQ];
  st_t state_nx [NREQ];
  logic [IW-1:0] ptr, gidx, ret_idx;
  logic [NREQ-1:0] elig, rsp_v, nidle;
  logic found, ret_vld;
  logic [NREQ-1:0][31:0] data_q;
  // Gating eligibility with rst keeps req_ready low for the whole reset pulse.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = bus.req_valid[i] && state[i] == IDLE && !rst;
      rsp_v[i] = state[i] == DONE;
      nidle[i] = state[i] != IDLE;
    end
  end
  always_comb begin
    found = 1'b0;
    gidx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && elig[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        gidx = IW'((int'(ptr) + k) % NREQ);
      end
    end
  end
  assign bus.req_ready = found ? NREQ'(1) << gidx : '0;
  assign bus.add_valid = found;
  assign bus.add_a = found ? bus.req_a[{gidx, 5'd0} +: 32] : '0;
  assign bus.add_b = found ? bus.req_b[{gidx, 5'd0} +: 32] : '0;
  assign bus.rsp_valid = rsp_v;
  assign bus.rsp_data = data_q;
  assign bus.busy = |nidle;
  // Each tag stage records the owner of one adder slot. The last stage lines up with add_res.
  generate
    if (LAT == 0) begin : g_comb
      assign ret_vld = found;
      assign ret_idx = gidx;
    end else begin : g_pipe
      logic [LAT-1:0] tvld;
      logic [LAT-1:0][IW-1:0] tidx;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          tvld <= '0;
          tidx <= '0;
        end else begin
          tvld[0] <= found;
          tidx[0] <= gidx;
          for (int k = 1; k < LAT; k++) begin
            tvld[k] <= tvld[k-1];
            tidx[k] <= tidx[k-1];
          end
        end
      end
      assign ret_vld = tvld[LAT-1];
      assign ret_idx = tidx[LAT-1];
    end
  endgenerate
  // When LAT is 0, issue and return fall in the same cycle, so the return overrides INFLIGHT.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      state_nx[i] = state[i];
      if (bus.req_ready[i]) state_nx[i] = INFLIGHT;
      if (ret_vld && ret_idx == IW'(i)) state_nx[i] = DONE;
      if (state[i] == DONE && bus.rsp_ready[i]) state_nx[i] = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
      data_q <= '0;
      for (int i = 0; i < NREQ; i++) state[i] <= IDLE;
    end else begin
      if (found) ptr <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
      if (ret_vld) data_q[ret_idx] <= bus.add_res;
      for (int i = 0; i < NREQ; i++) state[i] <= state_nx[i];
    end
  end
  a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.req_ready));
  a_tag: assert property (@(posedge clk) disable iff (rst)
    (LAT == 0 || !ret_vld || state[ret_idx] == INFLIGHT));
endmodule
